// File: rtl/updown_level_counter.sv
// updown_level_counter: up/down occupancy counter for FIFO and credit tracking.
// Each cycle it can add and subtract a multi-step amount. The count is clamped
// to a programmable ceiling. It drives registered full/empty and
// almost-full/almost-empty flags, plus sticky overflow and underflow errors.
// Optional build macro UPDOWN_LEVEL_COUNTER_WRAP_EN: when defined, out-of-range
// results wrap modulo (MAX_VAL+1) instead of saturating; ovf/udf are still set.
module updown_level_counter #(
    parameter int N_BITS    = 4,
    parameter int STEP_BITS = 2,
    parameter int MAX_VAL   = 2**N_BITS-1,
    parameter int AF_THRESH = MAX_VAL-1,
    parameter int AE_THRESH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 load,
    input  logic [N_BITS-1:0]    load_val,
    input  logic                 inc,
    input  logic [STEP_BITS-1:0] inc_amt,
    input  logic                 dec,
    input  logic [STEP_BITS-1:0] dec_amt,
    output logic [N_BITS-1:0]    cnt,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 ovf,
    output logic                 udf
);

    // The arithmetic width leaves room for cnt + max step and for a negative
    // result, so no intermediate value is ever truncated.
    localparam int W = N_BITS + STEP_BITS + 2;

    localparam logic signed [W-1:0]    MAX_S = W'(MAX_VAL);
    localparam logic [N_BITS-1:0]      MAX_N = N_BITS'(MAX_VAL);
    localparam logic signed [W-1:0]    AF_S  = W'(AF_THRESH);
    localparam logic signed [W-1:0]    AE_S  = W'(AE_THRESH);
`ifdef UPDOWN_LEVEL_COUNTER_WRAP_EN
    localparam logic signed [W-1:0]    RANGE_S = W'(MAX_VAL + 1);
`endif

    logic signed [W-1:0] inc_ext;
    logic signed [W-1:0] dec_ext;
    logic signed [W-1:0] delta;
    logic signed [W-1:0] next_sum;
    logic [N_BITS-1:0]   cnt_d;
    logic                ovf_d;
    logic                udf_d;
    logic [3:0]          flags_d;

    // The status flags are derived from a count value, packed as
    // {full, empty, almost_full, almost_empty}.
    function automatic logic [3:0] decode_flags(input logic [N_BITS-1:0] v);
        logic signed [W-1:0] ext;
        ext = $signed({{(W-N_BITS){1'b0}}, v});
        return {ext == MAX_S, ext == '0, ext >= AF_S, ext <= AE_S};
    endfunction

    // Compute the next count. Clear has the highest priority, then load, then
    // the net inc/dec step. An out-of-range step saturates or wraps and sets
    // the sticky ovf/udf error.
    always_comb begin
        inc_ext  = $signed({{(W-STEP_BITS){1'b0}}, inc_amt});
        dec_ext  = $signed({{(W-STEP_BITS){1'b0}}, dec_amt});
        delta    = (inc ? inc_ext : '0) - (dec ? dec_ext : '0);
        next_sum = $signed({{(W-N_BITS){1'b0}}, cnt}) + delta;
        cnt_d    = cnt;
        ovf_d    = ovf;
        udf_d    = udf;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else if (load) begin
            cnt_d = (load_val > MAX_N) ? MAX_N : load_val;
        end else if (next_sum > MAX_S) begin
            ovf_d = 1'b1;
`ifdef UPDOWN_LEVEL_COUNTER_WRAP_EN
            cnt_d = N_BITS'(next_sum - RANGE_S);
`else
            cnt_d = MAX_N;
`endif
        end else if (next_sum[W-1]) begin
            udf_d = 1'b1;
`ifdef UPDOWN_LEVEL_COUNTER_WRAP_EN
            cnt_d = N_BITS'(next_sum + RANGE_S);
`else
            cnt_d = '0;
`endif
        end else begin
            cnt_d = N_BITS'(next_sum);
        end
        flags_d = decode_flags(cnt_d);
    end

    // Register the count, the error flags and the decoded status together.
    // This way every output changes on the same edge and cannot glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
            {full, empty, almost_full, almost_empty} <= decode_flags('0);
        end else begin
            cnt <= cnt_d;
            ovf <= ovf_d;
            udf <= udf_d;
            {full, empty, almost_full, almost_empty} <= flags_d;
        end
    end

endmodule

// File: doc/updown_level_counter.md
Name: updown_level_counter

Overview:
- Parametrised up/down occupancy counter with multi-step increment/decrement, programmable ceiling, saturation, almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Successor to the single-step occupancy counter. Intended as the level tracker inside FIFO controllers and credit managers that push or pop more than one entry per cycle.

Parameters:
- N_BITS, 4, width of count.
- STEP_BITS, 2, width of inc_amt/dec_amt; the step range is 0..2^STEP_BITS-1.
- MAX_VAL, 2**N_BITS-1, ceiling value. Must be ≤ 2^N_BITS-1 and ≥ 1.
- AF_THRESH, MAX_VAL-1, almost_full asserts when cnt ≥ AF_THRESH.
- AE_THRESH, 1, almost_empty asserts when cnt ≤ AE_THRESH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear; highest priority after reset.
- load  in  1  synchronous load of load_val.
- load_val  in  N_BITS  value to load; values above MAX_VAL are clamped to MAX_VAL.
- inc  in  1  increment request.
- inc_amt  in  STEP_BITS  increment amount.
- dec  in  1  decrement request.
- dec_amt  in  STEP_BITS  decrement amount.
- cnt  out  N_BITS  registered count.
- full  out  1  cnt == MAX_VAL.
- empty  out  1  cnt == 0.
- almost_full  out  1  cnt ≥ AF_THRESH.
- almost_empty  out  1  cnt ≤ AE_THRESH.
- ovf  out  1  sticky overflow error.
- udf  out  1  sticky underflow error.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: cnt=0, empty=1, almost_empty=1 (AE_THRESH ≥ 0), full=0, almost_full=0 (for AF_THRESH > 0), ovf=0, udf=0. Reset asserted mid-operation clears everything immediately, independent of clk.
- Priority per cycle: clr > load > inc/dec.
  - clr: cnt=0 and ovf/udf cleared.
  - load: cnt=min(load_val, MAX_VAL); ovf/udf unchanged.
- Arithmetic: delta = (inc ? inc_amt : 0) − (dec ? dec_amt : 0), computed signed in N_BITS+STEP_BITS+2 bits with no intermediate truncation. next = cnt + delta.
- Simultaneous inc and dec apply the net delta in one cycle. Example: inc_amt=2, dec_amt=2 leaves cnt unchanged and no error.
- inc or dec asserted with an amount of 0 is a no-op.
- Overflow (next > MAX_VAL): cnt=MAX_VAL (saturate), ovf←1.
- Underflow (next < 0): cnt=0 (saturate), udf←1.
- ovf and udf are sticky until clr or reset.
- Latency: one cycle. cnt and all status flags are registered and reflect the new count on the same edge that updates cnt.
- Status flags are a pure function of registered cnt; they never glitch between edges.
- Thresholds with AF_THRESH > MAX_VAL make almost_full never assert; this is legal.

Optional Feature:
- Macro: UPDOWN_LEVEL_COUNTER_WRAP_EN.
- Defined: overflow and underflow wrap modulo (MAX_VAL+1) instead of saturating.
  - next > MAX_VAL gives cnt = next − (MAX_VAL+1).
  - next < 0 gives cnt = next + (MAX_VAL+1).
  - ovf/udf are still set sticky on wrap.
- Undefined: saturating behaviour as above.
- All other behaviour is identical in both builds.

Test Plan (N_BITS=4, STEP_BITS=2, MAX_VAL=12, AF_THRESH=10, AE_THRESH=2 unless noted):
- Reset/idle: assert rst_n=0 mid-count at cnt=7 → cnt=0, empty=1, almost_empty=1 asynchronously; holding inc=dec=0 for 5 cycles keeps cnt=0.
- Multi-step up: inc=1, inc_amt=3 for 4 cycles → cnt 3,6,9,12. almost_full rises with cnt=12 (the count skips 10); full=1 at 12; ovf=0.
- Saturate high: at cnt=12, inc_amt=2 → cnt stays 12, ovf=1. A following clr → cnt=0, ovf=0.
- Simultaneous: cnt=5, inc_amt=3 and dec_amt=1 together → cnt=7. Then inc_amt=2, dec_amt=2 → cnt=7, no flags change.
- Underflow and load: cnt=1, dec_amt=3 → cnt=0, udf=1. Then load=1, load_val=15 → cnt=12, full=1, udf remains 1. Then clr and load together → cnt=0.
- Wrap build (UPDOWN_LEVEL_COUNTER_WRAP_EN defined): cnt=11, inc_amt=3 → cnt=1, ovf=1. cnt=1, dec_amt=3 → cnt=11, udf=1.
